ad_ip_jesd204_tpl_adc_capture_gate: RTL and testbench
=====================================================

# ad_ip_jesd204_tpl_adc_capture_gate

Sample-gating stage for the TPL ADC data path, placed between the deframer core output and the DMA interface. Arms on a software request and starts passing beats either immediately or on an external sync edge, after a programmable delay. Passes either a fixed number of beats or runs continuously, and accounts for DMA overflows during the capture. Generalises the single-shot sync arming of the TPL ADC to a multi-mode, length-limited, optionally timestamped capture.

## Interface
- NUM_CHANNELS, 4, converter channels (M)
- DATA_PATH_WIDTH, 2, samples per channel per beat
- BITS_PER_SAMPLE, 16, sample container width (NP)
- CAPTURE_WIDTH, 24, width of the capture length counter
- DATA_WIDTH, NUM_CHANNELS*DATA_PATH_WIDTH*BITS_PER_SAMPLE, derived, not to be overridden
- clk  in  1  link clock; every signal is synchronous to it
- resetn  in  1  asynchronous, active-low reset
- data_in_valid  in  1  deframed beat valid
- data_in  in  DATA_WIDTH  deframed samples, channel-major
- enable  in  NUM_CHANNELS  per-channel DMA enable, from the regmap, quasi-static
- adc_sync_arm  in  1  single-cycle arm request
- adc_sync_abort  in  1  single-cycle abort request
- adc_sync_mode  in  1  0 = wait for adc_sync_in rising edge, 1 = trigger immediately
- adc_sync_in  in  1  external trigger, already synchronous to clk
- trig_delay  in  16  valid beats to skip after trigger
- capture_len  in  CAPTURE_WIDTH  beats to pass; 0 = continuous
- adc_dovf  in  1  DMA overflow flag
- adc_valid  out  NUM_CHANNELS  per-channel output valid
- adc_data  out  DATA_WIDTH  registered copy of data_in
- adc_sync_status  out  1  1 while ARMED or DELAY
- capture_done  out  1  1 while in DONE
- ovf_count  out  16  saturating count of adc_dovf cycles during RUN
- trig_timestamp  out  48  beat index at RUN entry (see Configuration)

## Operation
- States: IDLE, ARMED, DELAY, RUN, DONE. The reset state is IDLE.
- Any state on adc_sync_arm goes to ARMED. The arm also clears the delay counter, the length counter and ovf_count. trig_delay, capture_len and adc_sync_mode are sampled at the arm.
- Any state on adc_sync_abort goes to IDLE. Abort wins over a simultaneous arm.
- ARMED: the trigger is mode=1 (next cycle) or a rising edge on adc_sync_in (sync_in & ~sync_in_d, with sync_in_d registered). On trigger, go to RUN if trig_delay==0, else go to DELAY.
- DELAY: count data_in_valid beats. Go to RUN in the cycle after the trig_delay-th beat.
- RUN: every data_in_valid beat is passed. The length counter increments per passed beat. When capture_len!=0 and the count reaches capture_len, go to DONE in the next cycle. The capture_len-th beat is the last beat passed.
- DONE: hold until an arm or an abort.
- Gating: adc_valid <= {NUM_CHANNELS{data_in_valid & (state==RUN)}} & enable. The state used is the registered state of the current cycle.
- adc_data <= data_in every cycle, regardless of valid.
- ovf_count increments in cycles where state==RUN and adc_dovf=1. It saturates at 0xFFFF.
- An adc_sync_in edge outside ARMED is ignored. An arm received in RUN stops passing beats from the next cycle.

## Timing
- Reset values: adc_valid=0, adc_data=0, adc_sync_status=0, capture_done=0, ovf_count=0, trig_timestamp=0, sync_in_d=0.
- Data latency: data_in to adc_data is 1 cycle.
- Trigger to first output, zero delay: an edge in cycle k means the state is RUN at k+1. The first passed beat is the beat presented at k+1, and it appears on adc_valid at k+2.
- adc_sync_status and capture_done are registered decodes of the state. They change 1 cycle after the state transition.
- No backpressure: the block never stalls the input. Overflow is only accounted, never prevented.

## Configuration
- TPL_ADC_CAPTURE_TIMESTAMP_EN defined:
  - A 48-bit counter counts data_in_valid beats from reset and wraps modulo 2^48.
  - Its value in the RUN-entry cycle is latched into trig_timestamp.
  - trig_timestamp holds until the next RUN entry. Reset value is 0.
- Not defined: the counter is omitted and trig_timestamp is tied to 0.

## Test plan
- Immediate mode: mode=1, delay=0, len=4, valid constant. Required response: exactly 4 consecutive adc_valid beats, starting 3 cycles after the arm, carrying the matching data_in. Then capture_done=1.
- External trigger: mode=0, delay=3, len=0. Required response: no adc_valid before the sync_in edge, or during the 3 valid beats after it. Then continuous output. adc_sync_status=1 from arm+1 until RUN entry+1.
- Enable mask: enable=4'b0101 during RUN. Required response: adc_valid=4'b0101 on valid beats and 0 on beats with data_in_valid=0.
- Abort and arm together mid-RUN, followed by a sync_in edge. Required response: state goes to IDLE, adc_valid drops after 1 cycle, and the later sync_in edge is ignored.
- Overflow: adc_dovf held high for 70000 cycles in RUN. Required response: ovf_count=0xFFFF. The next arm sets ovf_count=0.
- Macro defined, 100 valid beats after reset, then an immediate trigger. Required response: trig_timestamp=100. With the macro undefined, trig_timestamp=0.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_adc_capture_gate.sv
// ad_ip_jesd204_tpl_adc_capture_gate
// Sample gate between the TPL ADC deframer output and the DMA interface.
// A software arm selects immediate or sync-edge triggering, then a
// programmable beat delay, then a length-limited or continuous capture.
// DMA overflows seen during the capture are counted with saturation.
// Optional feature macro: TPL_ADC_CAPTURE_TIMESTAMP_EN. When it is defined,
// a free-running beat counter is latched into trig_timestamp at RUN entry.
// When it is undefined, trig_timestamp is tied to zero.
module ad_ip_jesd204_tpl_adc_capture_gate #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_PATH_WIDTH = 2,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int CAPTURE_WIDTH   = 24,
  localparam int DATA_WIDTH     = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     data_in_valid,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [NUM_CHANNELS-1:0]  enable,
  input  logic                     adc_sync_arm,
  input  logic                     adc_sync_abort,
  input  logic                     adc_sync_mode,
  input  logic                     adc_sync_in,
  input  logic [15:0]              trig_delay,
  input  logic [CAPTURE_WIDTH-1:0] capture_len,
  input  logic                     adc_dovf,
  output logic [NUM_CHANNELS-1:0]  adc_valid,
  output logic [DATA_WIDTH-1:0]    adc_data,
  output logic                     adc_sync_status,
  output logic                     capture_done,
  output logic [15:0]              ovf_count,
  output logic [47:0]              trig_timestamp
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]               r_state;
  logic [2:0]               w_next_state;
  logic                     r_sync_in_d;
  logic                     r_mode;
  logic [15:0]              r_delay;
  logic [CAPTURE_WIDTH-1:0] r_len;
  logic [15:0]              r_delay_cnt;
  logic [CAPTURE_WIDTH-1:0] r_len_cnt;
  logic [15:0]              w_delay_cnt_inc;
  logic [CAPTURE_WIDTH-1:0] w_len_cnt_inc;
  logic                     w_arm;
  logic                     w_trigger;
  logic                     w_run;

  // Abort beats a simultaneous arm, so an arm only counts without abort.
  assign w_arm           = adc_sync_arm & ~adc_sync_abort;
  assign w_trigger       = r_mode | (adc_sync_in & ~r_sync_in_d);
  assign w_run           = (r_state == ST_RUN);
  assign w_delay_cnt_inc = r_delay_cnt + 16'd1;
  assign w_len_cnt_inc   = r_len_cnt + CAPTURE_WIDTH'(1);

  // Next-state decode; abort and arm override the per-state transitions.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_ARMED: if (w_trigger) w_next_state = (r_delay == 16'd0) ? ST_RUN : ST_DELAY;
      ST_DELAY: if (data_in_valid && (w_delay_cnt_inc == r_delay)) w_next_state = ST_RUN;
      ST_RUN:   if (data_in_valid && (r_len != '0) && (w_len_cnt_inc == r_len))
                  w_next_state = ST_DONE;
      ST_IDLE, ST_DONE: w_next_state = r_state;
      default:  w_next_state = ST_IDLE;
    endcase
    if (adc_sync_arm)   w_next_state = ST_ARMED;
    if (adc_sync_abort) w_next_state = ST_IDLE;
  end

  // State register and sync-edge history.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state     <= ST_IDLE;
      r_sync_in_d <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_sync_in_d <= adc_sync_in;
    end
  end

  // Capture configuration is sampled at the arm and held for the capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode  <= 1'b0;
      r_delay <= '0;
      r_len   <= '0;
    end else if (w_arm) begin
      r_mode  <= adc_sync_mode;
      r_delay <= trig_delay;
      r_len   <= capture_len;
    end
  end

  // Delay and length counters count valid beats in their own state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_delay_cnt <= '0;
      r_len_cnt   <= '0;
    end else if (w_arm) begin
      r_delay_cnt <= '0;
      r_len_cnt   <= '0;
    end else begin
      if ((r_state == ST_DELAY) && data_in_valid) r_delay_cnt <= w_delay_cnt_inc;
      if (w_run && data_in_valid)                  r_len_cnt   <= w_len_cnt_inc;
    end
  end

  // Saturating count of DMA overflow cycles seen while capturing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_count <= '0;
    end else if (w_arm) begin
      ovf_count <= '0;
    end else if (w_run && adc_dovf && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

  // Output stage: gated valid, data pipeline and registered state decodes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adc_valid       <= '0;
      adc_data        <= '0;
      adc_sync_status <= 1'b0;
      capture_done    <= 1'b0;
    end else begin
      adc_valid       <= {NUM_CHANNELS{data_in_valid & w_run}} & enable;
      adc_data        <= data_in;
      adc_sync_status <= (r_state == ST_ARMED) || (r_state == ST_DELAY);
      capture_done    <= (r_state == ST_DONE);
    end
  end

`ifdef TPL_ADC_CAPTURE_TIMESTAMP_EN
  logic [47:0] r_beat_cnt;

  // Free-running beat index; the value it will hold in the RUN-entry
  // cycle is latched on the transition into RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_cnt     <= '0;
      trig_timestamp <= '0;
    end else begin
      if (data_in_valid) r_beat_cnt <= r_beat_cnt + 48'd1;
      if ((w_next_state == ST_RUN) && !w_run)
        trig_timestamp <= r_beat_cnt + 48'(data_in_valid);
    end
  end
`else
  assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_gate.sv
// Self-checking bench for ad_ip_jesd204_tpl_adc_capture_gate.
// Table-driven vectors for immediate/external triggering, enable masking
// and abort, plus hand-written sequences for timestamp and overflow.
module tb_ad_ip_jesd204_tpl_adc_capture_gate;

  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic          data_in_valid;
  logic [DW-1:0] data_in;
  logic [3:0]    enable;
  logic          adc_sync_arm;
  logic          adc_sync_abort;
  logic          adc_sync_mode;
  logic          adc_sync_in;
  logic [15:0]   trig_delay;
  logic [23:0]   capture_len;
  logic          adc_dovf;
  logic [3:0]    adc_valid;
  logic [DW-1:0] adc_data;
  logic          adc_sync_status;
  logic          capture_done;
  logic [15:0]   ovf_count;
  logic [47:0]   trig_timestamp;

  int n_tests = 0;
  int n_fail  = 0;

  ad_ip_jesd204_tpl_adc_capture_gate dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_in_valid   (data_in_valid),
    .data_in         (data_in),
    .enable          (enable),
    .adc_sync_arm    (adc_sync_arm),
    .adc_sync_abort  (adc_sync_abort),
    .adc_sync_mode   (adc_sync_mode),
    .adc_sync_in     (adc_sync_in),
    .trig_delay      (trig_delay),
    .capture_len     (capture_len),
    .adc_dovf        (adc_dovf),
    .adc_valid       (adc_valid),
    .adc_data        (adc_data),
    .adc_sync_status (adc_sync_status),
    .capture_done    (capture_done),
    .ovf_count       (ovf_count),
    .trig_timestamp  (trig_timestamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic [3:0]    en;
    logic          arm;
    logic          abort;
    logic          mode;
    logic          sync;
    logic [15:0]   dly;
    logic [23:0]   len;
    logic [3:0]    exp_valid;
    logic          exp_status;
    logic          exp_done;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic vld, input logic [3:0] en, input logic arm,
                              input logic abort, input logic mode, input logic sync,
                              input logic [15:0] dly, input logic [23:0] len,
                              input logic [3:0] ev, input logic es, input logic ed);
    vec_t v;
    v.vld = vld; v.data = '0; v.en = en; v.arm = arm; v.abort = abort;
    v.mode = mode; v.sync = sync; v.dly = dly; v.len = len;
    v.exp_valid = ev; v.exp_status = es; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    logic [47:0] exp_ts;

    //            vld en    arm ab mode sync dly len | valid st done
    // Immediate mode, delay 0, length 4.
    tbl[0]  = mk(1, 4'hF, 1, 0, 1, 0, 16'd0, 24'd4, 4'h0, 0, 0);
    tbl[1]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'h0, 1, 0);
    tbl[2]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'hF, 0, 0);
    tbl[3]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'hF, 0, 0);
    tbl[4]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'hF, 0, 0);
    tbl[5]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'hF, 0, 0);
    tbl[6]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'h0, 0, 1);
    tbl[7]  = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd4, 4'h0, 0, 1);
    // External trigger, delay 3, continuous.
    tbl[8]  = mk(1, 4'hF, 1, 0, 0, 0, 16'd3, 24'd0, 4'h0, 0, 1);
    tbl[9]  = mk(1, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[10] = mk(1, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[11] = mk(1, 4'hF, 0, 0, 0, 1, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[12] = mk(1, 4'hF, 0, 0, 0, 1, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[13] = mk(0, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[14] = mk(1, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[15] = mk(1, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 1, 0);
    tbl[16] = mk(1, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'hF, 0, 0);
    tbl[17] = mk(0, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 0, 0);
    // Enable mask during RUN; sync edge inside RUN has no effect.
    tbl[18] = mk(1, 4'h5, 0, 0, 0, 1, 16'd3, 24'd0, 4'h5, 0, 0);
    tbl[19] = mk(0, 4'h5, 0, 0, 0, 0, 16'd3, 24'd0, 4'h0, 0, 0);
    tbl[20] = mk(1, 4'hF, 0, 0, 0, 0, 16'd3, 24'd0, 4'hF, 0, 0);
    // Abort together with arm mid-RUN, then an ignored sync edge.
    tbl[21] = mk(1, 4'hF, 1, 1, 1, 0, 16'd0, 24'd0, 4'hF, 0, 0);
    tbl[22] = mk(1, 4'hF, 0, 0, 1, 0, 16'd0, 24'd0, 4'h0, 0, 0);
    tbl[23] = mk(1, 4'hF, 0, 0, 0, 0, 16'd0, 24'd0, 4'h0, 0, 0);
    tbl[24] = mk(1, 4'hF, 0, 0, 0, 1, 16'd0, 24'd0, 4'h0, 0, 0);
    tbl[25] = mk(1, 4'hF, 0, 0, 0, 1, 16'd0, 24'd0, 4'h0, 0, 0);
    tbl[26] = mk(1, 4'hF, 0, 0, 0, 0, 16'd0, 24'd0, 4'h0, 0, 0);
    for (int i = 0; i < NVEC; i++) tbl[i].data = {4{32'hA5A50000 | 32'(i)}};

    // Reset
    resetn = 1'b0; data_in_valid = 1'b0; data_in = '0; enable = 4'hF;
    adc_sync_arm = 1'b0; adc_sync_abort = 1'b0; adc_sync_mode = 1'b0;
    adc_sync_in = 1'b0; trig_delay = '0; capture_len = '0; adc_dovf = 1'b0;
    data_in = {4{32'hDEADBEEF}};
    repeat (3) step();
    check("rst adc_valid", DW'(adc_valid), '0);
    check("rst adc_data", adc_data, '0);
    check("rst status", DW'(adc_sync_status), '0);
    check("rst done", DW'(capture_done), '0);
    check("rst ovf", DW'(ovf_count), '0);
    check("rst ts", DW'(trig_timestamp), '0);
    data_in = '0;
    resetn = 1'b1;
    step();

    // Timestamp: 100 valid beats from reset, then an immediate trigger.
    data_in_valid = 1'b1;
    repeat (100) step();
    data_in_valid = 1'b0;
    adc_sync_arm = 1'b1; adc_sync_mode = 1'b1; trig_delay = 16'd0; capture_len = 24'd0;
    step();
    adc_sync_arm = 1'b0;
    step();  // ARMED -> RUN at this edge
`ifdef TPL_ADC_CAPTURE_TIMESTAMP_EN
    exp_ts = 48'd100;
`else
    exp_ts = 48'd0;
`endif
    check("trig_timestamp", DW'(trig_timestamp), DW'(exp_ts));
    adc_sync_abort = 1'b1;
    step();
    adc_sync_abort = 1'b0;
    step();
    check("ts hold", DW'(trig_timestamp), DW'(exp_ts));

    // Vector table.
    for (int i = 0; i < NVEC; i++) begin
      data_in_valid  = tbl[i].vld;
      data_in        = tbl[i].data;
      enable         = tbl[i].en;
      adc_sync_arm   = tbl[i].arm;
      adc_sync_abort = tbl[i].abort;
      adc_sync_mode  = tbl[i].mode;
      adc_sync_in    = tbl[i].sync;
      trig_delay     = tbl[i].dly;
      capture_len    = tbl[i].len;
      step();
      check($sformatf("row%0d adc_valid", i), DW'(adc_valid), DW'(tbl[i].exp_valid));
      check($sformatf("row%0d adc_data", i), adc_data, tbl[i].data);
      check($sformatf("row%0d status", i), DW'(adc_sync_status), DW'(tbl[i].exp_status));
      check($sformatf("row%0d done", i), DW'(capture_done), DW'(tbl[i].exp_done));
    end
    adc_sync_arm = 1'b0; adc_sync_abort = 1'b0; adc_sync_in = 1'b0;

    // Overflow saturation over 70000 RUN cycles, then cleared by an arm.
    data_in_valid = 1'b1; enable = 4'hF;
    adc_sync_arm = 1'b1; adc_sync_mode = 1'b1; trig_delay = 16'd0; capture_len = 24'd0;
    step();
    adc_sync_arm = 1'b0;
    step();  // now in RUN
    adc_dovf = 1'b1;
    repeat (10) step();
    check("ovf 10", DW'(ovf_count), DW'(16'd10));
    repeat (69990) step();
    check("ovf sat", DW'(ovf_count), DW'(16'hFFFF));
    step();
    check("ovf sat hold", DW'(ovf_count), DW'(16'hFFFF));
    adc_dovf = 1'b0;
    adc_sync_arm = 1'b1;
    step();
    check("ovf arm clear", DW'(ovf_count), '0);
    adc_sync_arm = 1'b0;
    adc_sync_abort = 1'b1;
    step();
    adc_sync_abort = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
